// File: rtl/spi_ram_bridge_if.sv
// Command/response bundle between the SPI slave and the RAM bridge.
// master = SPI slave side, slave = RAM bridge side.
interface spi_ram_bridge_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output err
  );
endinterface

// File: rtl/spi_ram_bridge.sv
// Command-decoding RAM behind the SPI slave, auto-incrementing pointers.
// Define SPI_RAM_PROTO_CHECK_EN to flag data commands issued before an address.
module spi_ram_bridge #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input logic              clk,
  input logic              rst,
  spi_ram_bridge_if.slave  bus
);

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [7:0]           dout_q;
  logic                 tx_q;

  logic [1:0]           op;
  logic [ADDR_SIZE-1:0] addr;
  logic [7:0]           data;
  logic                 cmd_wa;
  logic                 cmd_wd;
  logic                 cmd_ra;
  logic                 cmd_rd;

  assign op   = bus.din[9:8];
  assign addr = bus.din[ADDR_SIZE-1:0];
  assign data = bus.din[7:0];

  always_comb begin
    cmd_wa = 1'b0;
    cmd_wd = 1'b0;
    cmd_ra = 1'b0;
    cmd_rd = 1'b0;
    if (bus.rx_valid) begin
      unique case (op)
        2'b00: cmd_wa = 1'b1;
        2'b01: cmd_wd = 1'b1;
        2'b10: cmd_ra = 1'b1;
        2'b11: cmd_rd = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout_q <= '0;
      tx_q   <= 1'b0;
    end else begin
      tx_q <= cmd_rd;
      if (cmd_wa)
        wr_ptr <= addr;
      else if (cmd_wd)
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      if (cmd_ra)
        rd_ptr <= addr;
      else if (cmd_rd) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
        dout_q <= mem[rd_ptr];
      end
    end
  end

  // Array has no reset; a write landing while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (cmd_wd && !rst)
      mem[wr_ptr] <= data;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_q;

`ifdef SPI_RAM_PROTO_CHECK_EN
  logic wr_set;
  logic rd_set;
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_set <= 1'b0;
      rd_set <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (cmd_wa)
        wr_set <= 1'b1;
      if (cmd_ra)
        rd_set <= 1'b1;
      if ((cmd_wd && !wr_set) || (cmd_rd && !rd_set))
        err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed bench for spi_ram_bridge with a reference model and
// a scoreboard queue of expected read bytes.
module tb_spi_ram_bridge;

`ifdef SPI_RAM_PROTO_CHECK_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_ram_bridge_if bus ();

  spi_ram_bridge #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         known;
    logic [7:0] val;
  } exp_t;

  exp_t       sbq [$];
  int         checks = 0;
  int         errors = 0;

  logic [7:0] mm    [256];
  bit         known [256];
  logic [7:0] mwp, mrp, mdout;
  bit         mws, mrs, merr, mdk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mwp   = 8'h00;
    mrp   = 8'h00;
    mws   = 1'b0;
    mrs   = 1'b0;
    merr  = 1'b0;
    mdout = 8'h00;
    mdk   = 1'b1;
    sbq.delete();
  endtask

  task automatic post_edge(bit exp_tx, string tag);
    exp_t e;
    #1;
    chk({tag, ":tx"}, {7'b0, bus.tx_valid}, {7'b0, exp_tx});
    if (bus.tx_valid === 1'b1) begin
      chk({tag, ":sb"}, 8'(sbq.size()), 8'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.known)
          chk({tag, ":dout"}, bus.dout, e.val);
      end
    end else if (mdk) begin
      chk({tag, ":hold"}, bus.dout, mdout);
    end
    chk({tag, ":err"}, {7'b0, bus.err}, {7'b0, merr});
  endtask

  task automatic send(logic [1:0] op, logic [7:0] p, string tag);
    exp_t e;
    @(negedge clk);
    bus.din      = {op, p};
    bus.rx_valid = 1'b1;
    case (op)
      2'b00: begin
        mwp = p;
        mws = 1'b1;
      end
      2'b01: begin
        if (!mws && PC_EN) merr = 1'b1;
        mm[mwp]    = p;
        known[mwp] = 1'b1;
        mwp        = mwp + 8'd1;
      end
      2'b10: begin
        mrp = p;
        mrs = 1'b1;
      end
      default: begin
        if (!mrs && PC_EN) merr = 1'b1;
        e.known = known[mrp];
        e.val   = mm[mrp];
        sbq.push_back(e);
        mdout = e.val;
        mdk   = e.known;
        mrp   = mrp + 8'd1;
      end
    endcase
    @(posedge clk);
    post_edge(op == 2'b11, tag);
  endtask

  task automatic idle(int n, string tag);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.din      = 10'($urandom);
      @(posedge clk);
      post_edge(1'b0, tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    model_reset();
    rst          = 1'b1;
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:tx", {7'b0, bus.tx_valid}, 8'h00);
    chk("rst:dout", bus.dout, 8'h00);
    chk("rst:err", {7'b0, bus.err}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // read before any address: flagged only with the check enabled
    send(2'b11, 8'h00, "early_rd");
    idle(1, "early_idle");

    send(2'b00, 8'h3C, "rt_wa");
    send(2'b01, 8'hA5, "rt_wd");
    send(2'b10, 8'h3C, "rt_ra");
    send(2'b11, 8'h00, "rt_rd");
    idle(2, "rt_idle");

    send(2'b00, 8'hFE, "wrap_wa");
    send(2'b01, 8'h11, "wrap_wd0");
    send(2'b01, 8'h22, "wrap_wd1");
    send(2'b01, 8'h33, "wrap_wd2");
    send(2'b10, 8'hFE, "wrap_ra");
    send(2'b11, 8'h00, "wrap_rd0");
    send(2'b11, 8'hFF, "wrap_rd1");
    send(2'b11, 8'h5C, "wrap_rd2");
    idle(1, "wrap_idle");

    send(2'b00, 8'h40, "gap_wa");
    idle(1, "gap_i0");
    send(2'b01, 8'h77, "gap_wd0");
    idle(2, "gap_i1");
    send(2'b01, 8'h88, "gap_wd1");
    send(2'b10, 8'h40, "gap_ra");
    idle(1, "gap_i2");
    send(2'b11, 8'h00, "gap_rd0");
    idle(3, "gap_i3");
    send(2'b11, 8'h00, "gap_rd1");

    send(2'b10, 8'h10, "wtr_ra");
    send(2'b00, 8'h10, "wtr_wa");
    send(2'b01, 8'h5A, "wtr_wd");
    send(2'b11, 8'h00, "wtr_rd");
    idle(1, "wtr_idle");

    // async reset in the middle of a read burst
    send(2'b10, 8'h3C, "mid_ra");
    send(2'b11, 8'h00, "mid_rd0");
    send(2'b11, 8'h00, "mid_rd1");
    rst = 1'b1;
    #1;
    chk("arst:tx", {7'b0, bus.tx_valid}, 8'h00);
    chk("arst:dout", bus.dout, 8'h00);
    chk("arst:err", {7'b0, bus.err}, 8'h00);
    model_reset();
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    idle(1, "post_rst");

    // array contents survive reset
    send(2'b10, 8'h3C, "keep_ra");
    send(2'b11, 8'h00, "keep_rd");
    send(2'b00, 8'h3D, "keep_wa");
    send(2'b01, 8'hC3, "keep_wd");
    send(2'b11, 8'h00, "keep_rd1");
    idle(2, "end_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
